// File: rtl/seq_detect_ctrl.sv
// Word-to-serial sequencer for a Moore pattern detector: resets the detector,
// shifts each word MSB first, counts hits. Optional hit map via HIT_MAP_EN.
module seq_detect_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             det_rst,
    output logic             det_sin,
    input  logic             det_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CW-1:0]    res_count,
    output logic             busy
`ifdef HIT_MAP_EN
    ,
    output logic [WIDTH-1:0] res_map
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    hit_cnt_q, hit_cnt_d;
    logic             accept;

    assign accept = (state_q == S_IDLE) && in_valid;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        hit_cnt_d = hit_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shreg_d   = in_data;
                    bit_cnt_d = '0;
                    hit_cnt_d = '0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: state_d = S_SHIFT;
            S_SHIFT: begin
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + CW'(1);
                // det_done lags the serial stream by one cycle; bit 0 has no hit yet
                if ((bit_cnt_q != '0) && det_done) begin
                    hit_cnt_d = hit_cnt_q + CW'(1);
                end
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (det_done) begin
                    hit_cnt_d = hit_cnt_q + CW'(1);
                end
                state_d = S_REPORT;
            end
            S_REPORT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    // All handshake outputs are masked while reset is asserted
    assign in_ready  = rst && (state_q == S_IDLE);
    assign busy      = rst && (state_q != S_IDLE);
    assign res_valid = rst && (state_q == S_REPORT);
    assign res_count = res_valid ? hit_cnt_q : '0;
    assign det_rst   = !rst || (state_q == S_LOAD);
    assign det_sin   = rst && (state_q == S_SHIFT) && shreg_q[WIDTH-1];

`ifdef HIT_MAP_EN
    logic [WIDTH-1:0] map_q, map_d;
    logic [WIDTH-1:0] hit_mask;

    // A hit seen at SHIFT count c belongs to serial bit c-1, i.e. in_data[WIDTH-c]
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_hit_mask
        if (gi == 0) begin : g_last
            assign hit_mask[gi] = det_done && (state_q == S_DRAIN);
        end else begin : g_mid
            assign hit_mask[gi] = det_done && (state_q == S_SHIFT) &&
                                  (bit_cnt_q == CW'(WIDTH - gi));
        end
    end

    always_comb begin
        map_d = map_q | hit_mask;
        if (accept) begin
            map_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            map_q <= '0;
        end else begin
            map_q <= map_d;
        end
    end

    assign res_map = res_valid ? map_q : '0;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule
